mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
Parametrised memory access controller replacing the discrete MAR/MDR/trap-address mux glue between the control unit and the byte-addressed RAM.
- Accepts one request at a time from the control unit.
- Latches address and write data, resolves the trap-address override, checks size and alignment.
- Runs the MFA/MFC handshake with a bounded timeout.
- Returns size-extended read data with a done or fault pulse.

Parameters:
ADDR_W, 9, RAM address width in bits.
DATA_W, 32, data path width; must be 32 (byte/halfword/word sizes fixed).
TIMEOUT, 15, maximum ACCESS cycles waiting for ram_mfc before a timeout fault; range 1..255.

Ports:
Clk  in  1  system clock, rising edge.
reset  in  1  synchronous, active-low reset.
req  in  1  request strobe, sampled only in IDLE.
req_rw  in  1  1=read, 0=write.
req_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
req_signed  in  1  1=sign-extend read data, 0=zero-extend.
req_addr  in  ADDR_W  request address.
req_wdata  in  DATA_W  write data, right-aligned.
trap_sel  in  1  1=use trap_addr instead of req_addr (sampled with req).
trap_addr  in  ADDR_W  trap/vector address from control unit.
busy  out  1  high in any state other than IDLE.
done  out  1  one-cycle pulse on successful completion.
fault  out  1  one-cycle pulse on failed request.
fault_code  out  2  00 none, 01 misaligned, 10 timeout, 11 bad size; valid with fault, held until next req accepted.
rdata  out  DATA_W  extended read data; updated only on successful read.
ram_mfa  out  1  memory function active.
ram_rw  out  1  RAM read/write, mirrors latched req_rw.
ram_addr  out  ADDR_W  latched effective address.
ram_wdata  out  DATA_W  latched write data.
ram_size  out  2  latched size.
ram_mfc  in  1  memory function complete.
ram_rdata  in  DATA_W  RAM read data, right-aligned.

Behaviour:
- Reset (reset=0 at rising edge):
  - State goes to IDLE.
  - busy, done, fault, ram_mfa, ram_rw = 0.
  - fault_code = 00; rdata, ram_addr, ram_wdata, ram_size, timeout counter = 0.
  - Applies mid-operation: ram_mfa drops on that edge and no done/fault is issued.
- States: IDLE, ACCESS, COMPLETE, FAULT.
- IDLE, req=1:
  - Latch effective address: trap_addr if trap_sel else req_addr.
  - Latch rw, size, signed, wdata; clear fault_code and counter.
  - Check on the effective address:
    - size 11 -> FAULT, code 11.
    - halfword with addr[0]=1, or word with addr[1:0]!=00 -> FAULT, code 01.
    - otherwise -> ACCESS.
- ACCESS:
  - ram_mfa=1.
  - ram_mfc=1 -> COMPLETE; on a read, rdata is loaded from the extended ram_rdata on this edge.
  - ram_mfc=0 -> counter increments; when counter reaches TIMEOUT-1 with ram_mfc still 0 -> FAULT, code 10.
  - ram_mfc=1 on the final allowed cycle counts as success; mfc wins over timeout.
- COMPLETE: ram_mfa=0, done=1 for one cycle -> IDLE.
- FAULT: ram_mfa=0, fault=1 for one cycle -> IDLE. RAM is never accessed on size or alignment faults.
- Read extension:
  - byte uses bits [7:0]; halfword uses [15:0]; word passes through.
  - Upper bits are filled with the top data bit if req_signed, else 0.
- Latency: req at edge N -> ACCESS from N+1; ram_mfc first seen at edge M -> done high during cycle M+1. Minimum 3 cycles request-to-done.
- req while busy is ignored, with no queueing. req held high in IDLE after done starts a new access.
- ram_addr, ram_wdata, ram_size and ram_rw stay stable throughout ACCESS.
- A write leaves rdata unchanged. A faulted read leaves rdata unchanged.

Decomposition:
- Package mau_pkg holds:
  - state encoding (IDLE=2'd0, ACCESS=2'd1, COMPLETE=2'd2, FAULT=2'd3);
  - size codes SZ_BYTE/SZ_HALF/SZ_WORD/SZ_BAD;
  - fault codes FC_NONE/FC_MISALIGN/FC_TIMEOUT/FC_BADSIZE.
- One sub-module, mau_read_extend: combinational, inputs size, signed and raw data, output extended data.
- FSM, latches, alignment check and timeout counter stay in mem_access_unit.

Test Plan:
- Word read at 0x010, model raises mfc 2 cycles after mfa with ram_rdata=0xDEADBEEF -> ram_mfa held 3 cycles, done pulse, rdata=0xDEADBEEF, fault never asserted.
- Signed byte read at 0x003 with ram_rdata=0x00000080 -> rdata=0xFFFFFF80; same access unsigned -> rdata=0x00000080.
- Halfword write at 0x005 -> fault with fault_code=01 one cycle after req edge, ram_mfa never asserted; word read at 0x002 -> same result; req_size=11 -> fault_code=11.
- Read with model never raising mfc, TIMEOUT=15 -> ram_mfa high exactly 15 cycles, then fault with fault_code=10, rdata unchanged.
- trap_sel=1, trap_addr=0x1FC, req_addr=0x020, word read -> ram_addr=0x1FC throughout ACCESS, done pulse; req pulses issued during ACCESS are ignored.
- reset driven low during ACCESS -> next edge ram_mfa=0, busy=0, no done/fault; a subsequent request completes normally.

Source files
------------

// File: rtl/mau_pkg.sv
// Shared encodings for the memory access unit: FSM states, access sizes and fault codes.
package mau_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    COMPLETE = 2'd2,
    FAULT    = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_BAD  = 2'b11
  } size_t;

  typedef enum logic [1:0] {
    FC_NONE     = 2'b00,
    FC_MISALIGN = 2'b01,
    FC_TIMEOUT  = 2'b10,
    FC_BADSIZE  = 2'b11
  } fault_t;

  // Halfwords need an even address, words a 4-byte-aligned one.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    if (size == SZ_HALF && addr_lo[0]) bad = 1'b1;
    if (size == SZ_WORD && addr_lo != 2'b00) bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/mau_read_extend.sv
// Sign/zero extension of right-aligned RAM read data to the full data path width.
module mau_read_extend
  import mau_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]        size,
  input  logic              sgn,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] ext
);

  always_comb begin
    ext = data;
    case (size)
      SZ_BYTE: ext = {{(DATA_W-8){sgn & data[7]}}, data[7:0]};
      SZ_HALF: ext = {{(DATA_W-16){sgn & data[15]}}, data[15:0]};
      default: ext = data;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory access controller: latches a request, checks size/alignment, runs the
// MFA/MFC handshake with a bounded wait and returns extended read data.
//
// state    | meaning
// IDLE     | waiting for req; latches address/data and checks the request
// ACCESS   | ram_mfa high, waiting for ram_mfc or timeout
// COMPLETE | done pulse, back to IDLE
// FAULT    | fault pulse with fault_code, back to IDLE
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              req_rw,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              trap_sel,
  input  logic [ADDR_W-1:0] trap_addr,
  output logic              busy,
  output logic              done,
  output logic              fault,
  output logic [1:0]        fault_code,
  output logic [DATA_W-1:0] rdata,
  output logic              ram_mfa,
  output logic              ram_rw,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [1:0]        ram_size,
  input  logic              ram_mfc,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam logic [7:0] TC = 8'(TIMEOUT - 1);

  state_t            state;
  logic [7:0]        cnt;
  logic              sgn_q;
  logic [ADDR_W-1:0] eff_addr;
  logic [DATA_W-1:0] ext_data;

  assign eff_addr = trap_sel ? trap_addr : req_addr;

  mau_read_extend #(.DATA_W(DATA_W)) u_extend (
    .size (ram_size),
    .sgn  (sgn_q),
    .data (ram_rdata),
    .ext  (ext_data)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      fault      <= 1'b0;
      fault_code <= FC_NONE;
      rdata      <= '0;
      ram_mfa    <= 1'b0;
      ram_rw     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      ram_size   <= SZ_BYTE;
      sgn_q      <= 1'b0;
      cnt        <= '0;
    end else begin
      done  <= 1'b0;
      fault <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            busy       <= 1'b1;
            ram_addr   <= eff_addr;
            ram_rw     <= req_rw;
            ram_size   <= req_size;
            ram_wdata  <= req_wdata;
            sgn_q      <= req_signed;
            fault_code <= FC_NONE;
            cnt        <= '0;
            if (req_size == SZ_BAD) begin
              state      <= FAULT;
              fault      <= 1'b1;
              fault_code <= FC_BADSIZE;
            end else if (misaligned(req_size, eff_addr[1:0])) begin
              state      <= FAULT;
              fault      <= 1'b1;
              fault_code <= FC_MISALIGN;
            end else begin
              state   <= ACCESS;
              ram_mfa <= 1'b1;
            end
          end
        end
        ACCESS: begin
          // mfc on the last allowed cycle still counts as success
          if (ram_mfc) begin
            ram_mfa <= 1'b0;
            state   <= COMPLETE;
            done    <= 1'b1;
            if (ram_rw) rdata <= ext_data;
          end else if (cnt == TC) begin
            ram_mfa    <= 1'b0;
            state      <= FAULT;
            fault      <= 1'b1;
            fault_code <= FC_TIMEOUT;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        COMPLETE, FAULT: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a small MFA/MFC RAM responder.
module tb_mem_access_unit;
  import mau_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req = 1'b0;
  logic        req_rw = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [8:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        trap_sel = 1'b0;
  logic [8:0]  trap_addr = '0;
  logic        ram_mfc = 1'b0;
  logic [31:0] ram_rdata = '0;
  logic        busy, done, fault, ram_mfa, ram_rw;
  logic [1:0]  fault_code, ram_size;
  logic [31:0] rdata, ram_wdata;
  logic [8:0]  ram_addr;

  mem_access_unit #(.ADDR_W(9), .DATA_W(32), .TIMEOUT(15)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_rw     (req_rw),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .trap_sel   (trap_sel),
    .trap_addr  (trap_addr),
    .busy       (busy),
    .done       (done),
    .fault      (fault),
    .fault_code (fault_code),
    .rdata      (rdata),
    .ram_mfa    (ram_mfa),
    .ram_rw     (ram_rw),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_size   (ram_size),
    .ram_mfc    (ram_mfc),
    .ram_rdata  (ram_rdata)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // RAM responder: raises mfc on the (mfc_delay+1)-th cycle of mfa; -1 = never.
  int         mfc_delay = 0;
  int         mfa_cnt = 0;
  int         mfa_total = 0;
  int         done_total = 0;
  int         fault_total = 0;
  int         addr_bad = 0;
  logic [8:0] exp_addr = '0;

  always @(negedge clk) begin
    if (ram_mfa) begin
      ram_mfc = (mfa_cnt == mfc_delay);
      mfa_cnt++;
      mfa_total++;
      if (ram_addr !== exp_addr) addr_bad++;
    end else begin
      ram_mfc = 1'b0;
      mfa_cnt = 0;
    end
    if (done) done_total++;
    if (fault) fault_total++;
  end

  task automatic do_req(input logic rw, input logic [1:0] size, input logic sgn,
                        input logic [8:0] addr, input logic [31:0] wdata,
                        input logic tsel, input logic [8:0] taddr,
                        input bit pulse, output int cycles);
    int guard;
    guard = 0;
    while (busy && guard < 50) begin
      @(negedge clk); #1;
      guard++;
    end
    if (busy) check("idle_wait", 32'(busy), 32'd0);
    exp_addr   = tsel ? taddr : addr;
    req_rw     = rw;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    trap_sel   = tsel;
    trap_addr  = taddr;
    req        = 1'b1;
    cycles     = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      cycles++;
      if (done || fault) break;
      req = pulse && (cycles % 2 == 0);
    end
    req = 1'b0;
    if (!(done || fault)) check("resp_bound", 32'(done | fault), 32'd1);
  endtask

  int cyc, m0, d0, f0, a0;

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mfa", 32'(ram_mfa), 32'd0);
    check("rst_done_fault", 32'({done, fault}), 32'd0);
    check("rst_fault_code", 32'(fault_code), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    reset = 1'b1;
    @(negedge clk); #1;

    // word read, mfc on third mfa cycle
    mfc_delay = 2; ram_rdata = 32'hDEADBEEF;
    m0 = mfa_total; f0 = fault_total;
    do_req(1'b1, SZ_WORD, 1'b0, 9'h010, 32'h0, 1'b0, 9'h0, 1'b0, cyc);
    check("w_rd_done", 32'(done), 32'd1);
    check("w_rd_latency", 32'(cyc), 32'd4);
    check("w_rd_rdata", rdata, 32'hDEADBEEF);
    check("w_rd_mfa_cycles", 32'(mfa_total - m0), 32'd3);
    check("w_rd_no_fault", 32'(fault_total - f0), 32'd0);

    // byte / halfword extension
    mfc_delay = 0; ram_rdata = 32'h00000080;
    do_req(1'b1, SZ_BYTE, 1'b1, 9'h003, 32'h0, 1'b0, 9'h0, 1'b0, cyc);
    check("sb_latency", 32'(cyc), 32'd2);
    check("sb_rdata", rdata, 32'hFFFFFF80);
    do_req(1'b1, SZ_BYTE, 1'b0, 9'h003, 32'h0, 1'b0, 9'h0, 1'b0, cyc);
    check("ub_rdata", rdata, 32'h00000080);
    ram_rdata = 32'h12348001;
    do_req(1'b1, SZ_HALF, 1'b1, 9'h002, 32'h0, 1'b0, 9'h0, 1'b0, cyc);
    check("sh_rdata", rdata, 32'hFFFF8001);
    do_req(1'b1, SZ_HALF, 1'b0, 9'h002, 32'h0, 1'b0, 9'h0, 1'b0, cyc);
    check("uh_rdata", rdata, 32'h00008001);

    // word write leaves rdata alone
    do_req(1'b0, SZ_WORD, 1'b0, 9'h004, 32'hCAFEF00D, 1'b0, 9'h0, 1'b0, cyc);
    check("wr_done", 32'(done), 32'd1);
    check("wr_wdata", ram_wdata, 32'hCAFEF00D);
    check("wr_rw", 32'(ram_rw), 32'd0);
    check("wr_rdata_kept", rdata, 32'h00008001);

    // size and alignment faults never touch RAM
    m0 = mfa_total;
    do_req(1'b0, SZ_HALF, 1'b0, 9'h005, 32'h1, 1'b0, 9'h0, 1'b0, cyc);
    check("mis_h_fault", 32'(fault), 32'd1);
    check("mis_h_latency", 32'(cyc), 32'd1);
    check("mis_h_code", 32'(fault_code), 32'(FC_MISALIGN));
    do_req(1'b1, SZ_WORD, 1'b0, 9'h002, 32'h0, 1'b0, 9'h0, 1'b0, cyc);
    check("mis_w_code", 32'(fault_code), 32'(FC_MISALIGN));
    check("mis_w_rdata_kept", rdata, 32'h00008001);
    do_req(1'b1, SZ_BAD, 1'b0, 9'h000, 32'h0, 1'b0, 9'h0, 1'b0, cyc);
    check("bad_size_code", 32'(fault_code), 32'(FC_BADSIZE));
    check("bad_no_mfa", 32'(mfa_total - m0), 32'd0);
    repeat (2) @(negedge clk);
    #1;
    check("code_held", 32'(fault_code), 32'(FC_BADSIZE));
    check("fault_one_pulse", 32'(fault), 32'd0);

    // timeout
    mfc_delay = -1; ram_rdata = 32'h11111111; m0 = mfa_total;
    do_req(1'b1, SZ_WORD, 1'b0, 9'h008, 32'h0, 1'b0, 9'h0, 1'b0, cyc);
    check("to_fault", 32'(fault), 32'd1);
    check("to_code", 32'(fault_code), 32'(FC_TIMEOUT));
    check("to_mfa_cycles", 32'(mfa_total - m0), 32'd15);
    check("to_latency", 32'(cyc), 32'd16);
    check("to_rdata_kept", rdata, 32'h00008001);

    // mfc on the last allowed cycle wins
    mfc_delay = 14; m0 = mfa_total;
    do_req(1'b1, SZ_WORD, 1'b0, 9'h00C, 32'h0, 1'b0, 9'h0, 1'b0, cyc);
    check("last_done", 32'(done), 32'd1);
    check("last_code", 32'(fault_code), 32'(FC_NONE));
    check("last_mfa_cycles", 32'(mfa_total - m0), 32'd15);
    check("last_rdata", rdata, 32'h11111111);

    // trap address override, req pulses during ACCESS ignored
    mfc_delay = 3; ram_rdata = 32'hA5A5A5A5;
    m0 = mfa_total; d0 = done_total; a0 = addr_bad;
    do_req(1'b1, SZ_WORD, 1'b0, 9'h020, 32'h0, 1'b1, 9'h1FC, 1'b1, cyc);
    check("trap_done", 32'(done), 32'd1);
    check("trap_ram_addr", 32'(ram_addr), 32'h1FC);
    check("trap_addr_stable", 32'(addr_bad - a0), 32'd0);
    check("trap_mfa_cycles", 32'(mfa_total - m0), 32'd4);
    check("trap_rdata", rdata, 32'hA5A5A5A5);
    trap_sel = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("trap_no_queue_busy", 32'(busy), 32'd0);
    check("trap_one_done", 32'(done_total - d0), 32'd1);

    // reset in the middle of ACCESS
    mfc_delay = -1; exp_addr = 9'h040;
    req_rw = 1'b1; req_size = SZ_WORD; req_addr = 9'h040; req = 1'b1;
    @(negedge clk); #1;
    req = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("mid_mfa_before", 32'(ram_mfa), 32'd1);
    d0 = done_total; f0 = fault_total;
    reset = 1'b0;
    @(negedge clk); #1;
    check("mid_rst_mfa", 32'(ram_mfa), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_rdata", rdata, 32'd0);
    reset = 1'b1;
    @(negedge clk); #1;
    check("mid_rst_no_pulse", 32'((done_total - d0) + (fault_total - f0)), 32'd0);
    mfc_delay = 1; ram_rdata = 32'h0BADF00D;
    do_req(1'b1, SZ_WORD, 1'b0, 9'h044, 32'h0, 1'b0, 9'h0, 1'b0, cyc);
    check("post_rst_done", 32'(done), 32'd1);
    check("post_rst_rdata", rdata, 32'h0BADF00D);
    check("addr_stable_all", 32'(addr_bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
